// File: rtl/pico_io_pkg.sv
// Shared constants and types for the pico_io_hub port peripheral.
package pico_io_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [7:0] ADDR_CTRL     = 8'hF0;
  localparam logic [7:0] ADDR_DIV_BASE = 8'hF4;

  localparam int unsigned CTRL_EN_BIT         = 0;
  localparam int unsigned CTRL_CLR_MISSED_BIT = 7;

  // Status byte layout as read back at ADDR_CTRL, MSB first.
  typedef struct packed {
    logic [4:0] rsvd;
    logic       missed;
    logic       enable;
    logic       pending;
  } status_t;

  // Divisor bytes occupy four consecutive addresses starting at ADDR_DIV_BASE.
  function automatic logic is_div_addr(logic [7:0] addr);
    return addr[7:2] == ADDR_DIV_BASE[7:2];
  endfunction

endpackage

// File: rtl/pico_io_hub_if.sv
// Port bus between the pacoblaze3 core (master) and the I/O hub (slave).
interface pico_io_hub_if;

  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;

  modport master (
    output port_id, out_port, write_strobe, read_strobe, interrupt_ack,
    input  in_port, interrupt
  );

  modport slave (
    input  port_id, out_port, write_strobe, read_strobe, interrupt_ack,
    output in_port, interrupt
  );

endinterface

// File: rtl/pico_io_timer.sv
// Programmable periodic tick with a pending interrupt flag and sticky missed flag.
module pico_io_timer
  import pico_io_pkg::*;
#(
  parameter int unsigned         TIMER_W   = 27,
  parameter logic [TIMER_W-1:0]  DIV_RESET = '1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ctrl_we_i,
  input  logic       div_we_i,
  input  logic [1:0] div_sel_i,
  input  logic [7:0] wdata_i,
  input  logic       ack_i,
  output logic       pending_o,
  output logic       missed_o,
  output logic       enable_o
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic [TIMER_W-1:0] div_q, div_d;
  logic [TIMER_W-1:0] byte_mask, byte_val;
  logic               en_q, en_d;
  logic               pending_q, pending_d;
  logic               missed_q, missed_d;
  logic               tick;

  always_comb begin
    tick = en_q && (cnt_q >= div_q);

    // Truncating casts drop divisor bits at or above TIMER_W.
    byte_mask = TIMER_W'(32'hFF << {div_sel_i, 3'b000});
    byte_val  = TIMER_W'({24'b0, wdata_i} << {div_sel_i, 3'b000});
    div_d     = div_we_i ? ((div_q & ~byte_mask) | byte_val) : div_q;

    if (div_we_i || !en_q || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    en_d      = ctrl_we_i ? wdata_i[CTRL_EN_BIT] : en_q;
    // A tick wins over a simultaneous ack, so the request is never lost.
    pending_d = tick | (pending_q & ~ack_i);

    missed_d = missed_q;
    if (ctrl_we_i && wdata_i[CTRL_CLR_MISSED_BIT]) begin
      missed_d = 1'b0;
    end
    if (tick && pending_q && !ack_i) begin
      missed_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      div_q     <= DIV_RESET;
      en_q      <= 1'b1;
      pending_q <= 1'b0;
      missed_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      en_q      <= en_d;
      pending_q <= pending_d;
      missed_q  <= missed_d;
    end
  end

  assign pending_o = pending_q;
  assign missed_o  = missed_q;
  assign enable_o  = en_q;

endmodule

// File: rtl/pico_io_hub.sv
// Output register bank, registered read mux and timer interrupt for a pacoblaze3 port bus.
// Define PICO_IO_SYNC_EN to add a two-flop synchronizer on every in_data bit.
module pico_io_hub
  import pico_io_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 25000000,
  parameter int unsigned TICK_HZ     = 1,
  parameter int unsigned NUM_OUT     = 4,
  parameter int unsigned NUM_IN      = 4,
  parameter int unsigned TIMER_W     = 27
) (
  input  logic                      clk,
  input  logic                      reset,
  pico_io_hub_if.slave              bus,
  input  logic [BYTE_W*NUM_IN-1:0]  in_data,
  output logic [BYTE_W*NUM_OUT-1:0] out_data
);

  localparam int unsigned        DivFull  = CLK_FREQ_HZ / TICK_HZ - 1;
  localparam logic [TIMER_W-1:0] DivReset = TIMER_W'(DivFull);

  logic [BYTE_W*NUM_OUT-1:0] out_q, out_d;
  logic [BYTE_W*NUM_IN-1:0]  in_sync;
  logic [7:0]                rd_q, rd_d;
  logic                      ctrl_we, div_we;
  logic                      pending, missed, enable;
  status_t                   status;
  logic                      unused_rd_strobe;

  // The read mux runs every cycle; read_strobe carries no meaning here.
  assign unused_rd_strobe = bus.read_strobe;

`ifdef PICO_IO_SYNC_EN
  logic [BYTE_W*NUM_IN-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

  always_comb begin
    sync1_d = in_data;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign in_sync = sync2_q;
`else
  assign in_sync = in_data;
`endif

  assign ctrl_we = bus.write_strobe && (bus.port_id == ADDR_CTRL);
  assign div_we  = bus.write_strobe && is_div_addr(bus.port_id);

  pico_io_timer #(
    .TIMER_W   (TIMER_W),
    .DIV_RESET (DivReset)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .ctrl_we_i (ctrl_we),
    .div_we_i  (div_we),
    .div_sel_i (bus.port_id[1:0]),
    .wdata_i   (bus.out_port),
    .ack_i     (bus.interrupt_ack),
    .pending_o (pending),
    .missed_o  (missed),
    .enable_o  (enable)
  );

  always_comb begin
    status         = '0;
    status.missed  = missed;
    status.enable  = enable;
    status.pending = pending;

    out_d = out_q;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (bus.write_strobe && (bus.port_id == 8'(k))) begin
        out_d[BYTE_W*k +: BYTE_W] = bus.out_port;
      end
    end

    rd_d = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.port_id == 8'(k)) begin
        rd_d = in_sync[BYTE_W*k +: BYTE_W];
      end
    end
    if (bus.port_id == ADDR_CTRL) begin
      rd_d = status;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
      rd_q  <= '0;
    end else begin
      out_q <= out_d;
      rd_q  <= rd_d;
    end
  end

  assign out_data      = out_q;
  assign bus.in_port   = rd_q;
  assign bus.interrupt = pending;

endmodule

// File: tb/tb_pico_io_hub.sv
// Directed and randomized bench for pico_io_hub, checked against a cycle model of the port map.
module tb_pico_io_hub;

  localparam int unsigned NUM_OUT  = 4;
  localparam int unsigned NUM_IN   = 4;
  localparam int unsigned TIMER_W  = 27;
  localparam int unsigned DEF_DIV  = 1000 / 50 - 1;
  localparam int unsigned DIV_MASK = (32'd1 << TIMER_W) - 1;

  logic        clk;
  logic        reset;
  logic [31:0] in_data;
  logic [31:0] out_data;
  int          checks;
  int          errors;

  pico_io_hub_if bus ();

  pico_io_hub #(
    .CLK_FREQ_HZ (1000),
    .TICK_HZ     (50),
    .NUM_OUT     (NUM_OUT),
    .NUM_IN      (NUM_IN),
    .TIMER_W     (TIMER_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .in_data  (in_data),
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state, advanced once per rising edge from the sampled inputs.
  logic [7:0]  m_out [NUM_OUT];
  logic [7:0]  m_inport;
  logic        m_en, m_pend, m_miss;
  int unsigned m_div, m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_out_vec();
    logic [31:0] v;
    for (int k = 0; k < NUM_OUT; k++) v[8*k +: 8] = m_out[k];
    return v;
  endfunction

  function automatic logic tick_next();
    return m_en && (m_cnt >= m_div);
  endfunction

  task automatic model_edge();
    logic [7:0] pid, op, stat;
    logic       ws, ack, tick, div_w, pend_old;
    int         p, i;
    if (reset) begin
      for (int k = 0; k < NUM_OUT; k++) m_out[k] = 8'h00;
      m_inport = 8'h00;
      m_en = 1'b1; m_pend = 1'b0; m_miss = 1'b0;
      m_div = DEF_DIV; m_cnt = 0;
      return;
    end
    pid = bus.port_id; op = bus.out_port; ws = bus.write_strobe; ack = bus.interrupt_ack;
    p = int'(pid);
    tick = tick_next();
    pend_old = m_pend;
    stat = {5'b0, m_miss, m_en, m_pend};
    if (p < NUM_IN) m_inport = 8'(in_data >> (8 * p));
    else if (pid == 8'hF0) m_inport = stat;
    else m_inport = 8'h00;
    if (ws && p < NUM_OUT) m_out[p] = op;
    div_w = ws && (pid >= 8'hF4) && (pid <= 8'hF7);
    if (div_w || !m_en || tick) m_cnt = 0;
    else m_cnt = m_cnt + 1;
    if (div_w) begin
      i = p - 'hF4;
      m_div = ((m_div & ~(32'hFF << (8 * i))) | (32'(op) << (8 * i))) & DIV_MASK;
    end
    if (ws && pid == 8'hF0 && op[7]) m_miss = 1'b0;
    if (tick && pend_old && !ack) m_miss = 1'b1;
    if (tick) m_pend = 1'b1;
    else if (ack) m_pend = 1'b0;
    if (ws && pid == 8'hF0) m_en = op[0];
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("out_data", out_data, m_out_vec());
    chk("in_port", 32'(bus.in_port), 32'(m_inport));
    chk("interrupt", 32'(bus.interrupt), 32'(m_pend));
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    bus.port_id = addr; bus.out_port = data; bus.write_strobe = 1'b1;
    cycle();
    bus.write_strobe = 1'b0;
  endtask

  task automatic wait_rise(input int bound, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (bus.interrupt !== 1'b1 && n < bound);
    chk("rise_seen", 32'(bus.interrupt), 32'd1);
  endtask

  initial begin
    int n;
    int seen;
    int sel;
    checks = 0; errors = 0;
    reset = 1'b1; in_data = '0;
    bus.port_id = 8'h00; bus.out_port = 8'h00; bus.write_strobe = 1'b0;
    bus.read_strobe = 1'b0; bus.interrupt_ack = 1'b0;

    // Reset state, then the default divisor gives a rise on the 20th edge.
    cycle(); cycle();
    chk("rst_out", out_data, 32'h0);
    chk("rst_inport", 32'(bus.in_port), 32'h0);
    chk("rst_irq", 32'(bus.interrupt), 32'h0);
    reset = 1'b0;
    wait_rise(40, n);
    chk("def_period", 32'(n), 32'd20);

    // Output writes, including an address past the last output register.
    wr(8'h02, 8'hA5);
    chk("out_wr", out_data, 32'h00A5_0000);
    wr(8'h05, 8'h3C);
    chk("out_ignored", out_data, 32'h00A5_0000);

    // Read mux latency and an unmapped read.
    in_data = 32'h7E00_0000;
    bus.port_id = 8'h03; cycle();
    chk("rd_port3", 32'(bus.in_port), 32'h7E);
    bus.port_id = 8'h10; cycle();
    chk("rd_unmapped", 32'(bus.in_port), 32'h00);

    // Divisor 9: 10-cycle period, ack two cycles after the rise.
    wr(8'hF4, 8'h09); wr(8'hF5, 8'h00); wr(8'hF6, 8'h00); wr(8'hF7, 8'h00);
    bus.interrupt_ack = 1'b1; cycle(); bus.interrupt_ack = 1'b0;
    wait_rise(20, n);
    cycle();
    bus.interrupt_ack = 1'b1; cycle(); bus.interrupt_ack = 1'b0;
    chk("ack_low", 32'(bus.interrupt), 32'd0);
    wait_rise(20, n);
    chk("period10", 32'(n), 32'd8);

    // No ack across the next tick sets missed; 0x81 clears it and keeps enable.
    repeat (10) cycle();
    bus.port_id = 8'hF0; cycle();
    chk("stat_missed", 32'(bus.in_port), 32'h07);
    wr(8'hF0, 8'h81);
    cycle();
    chk("stat_cleared", 32'(bus.in_port), 32'h03);

    // Ack on the exact tick cycle while pending.
    n = 0;
    while (!tick_next() && n < 30) begin cycle(); n++; end
    chk("tick_found", 32'(tick_next()), 32'd1);
    bus.interrupt_ack = 1'b1; cycle(); bus.interrupt_ack = 1'b0;
    chk("ack_on_tick", 32'(bus.interrupt), 32'd1);
    cycle();
    chk("ack_on_tick_stat", 32'(bus.in_port), 32'h03);

    // Disabled timer stays silent.
    bus.interrupt_ack = 1'b1; cycle(); bus.interrupt_ack = 1'b0;
    wr(8'hF0, 8'h00);
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      cycle();
      if (bus.interrupt === 1'b1) seen++;
    end
    chk("disabled_quiet", 32'(seen), 32'd0);
    chk("disabled_stat", 32'(bus.in_port), 32'h00);

    // Randomized traffic against the model.
    wr(8'hF4, 8'(3 + $urandom_range(0, 9)));
    wr(8'hF0, 8'h01);
    for (int c = 0; c < 400; c++) begin
      in_data = $urandom();
      bus.write_strobe = ($urandom_range(0, 9) < 4);
      bus.interrupt_ack = ($urandom_range(0, 3) == 0);
      bus.out_port = 8'($urandom());
      sel = $urandom_range(0, 6);
      if (sel <= 3) bus.port_id = 8'($urandom_range(0, 7));
      else if (sel == 4) begin
        bus.port_id = 8'hF0;
        bus.out_port[0] = ($urandom_range(0, 4) != 0);
      end else if (sel == 5) bus.port_id = 8'($urandom_range(16, 239));
      else begin
        bus.port_id = 8'hF4;
        bus.out_port = 8'($urandom_range(0, 20));
      end
      cycle();
    end
    bus.write_strobe = 1'b0; bus.interrupt_ack = 1'b0;

    // Reset overrides a simultaneous write and ack; default divisor returns.
    wr(8'h01, 8'h5A);
    reset = 1'b1; bus.write_strobe = 1'b1; bus.port_id = 8'h01; bus.interrupt_ack = 1'b1;
    cycle();
    reset = 1'b0; bus.write_strobe = 1'b0; bus.interrupt_ack = 1'b0;
    chk("mid_rst_out", out_data, 32'h0);
    chk("mid_rst_irq", 32'(bus.interrupt), 32'h0);
    chk("mid_rst_inport", 32'(bus.in_port), 32'h0);
    bus.port_id = 8'hF0; cycle();
    chk("mid_rst_stat", 32'(bus.in_port), 32'h02);
    wait_rise(40, n);
    chk("mid_rst_period", 32'(n), 32'd19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pico_io_hub.md
# pico_io_hub

Parametrised I/O and timer-interrupt peripheral for a pacoblaze3 core. Replaces hand-written per-design port logic with fully decoded banks of output registers, a registered input multiplexer and a programmable periodic-interrupt timer. The interrupt is held pending until the core acknowledges it. Sits directly on the core's port bus, beside the instruction memory.

## Interface
- CLK_FREQ_HZ, 25000000, system clock frequency
- TICK_HZ, 1, reset-default interrupt rate
- NUM_OUT, 4, number of 8-bit output registers (1..32)
- NUM_IN, 4, number of 8-bit input ports (1..32)
- TIMER_W, 27, timer counter/divisor width (9..32)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- port_id  in  8  core port address
- out_port  in  8  core write data
- write_strobe  in  1  core write qualifier
- read_strobe  in  1  core read qualifier (informational; the mux is not gated by it)
- in_port  out  8  registered read data to the core
- interrupt  out  1  pending interrupt request
- interrupt_ack  in  1  core interrupt acknowledge
- in_data  in  8*NUM_IN  external inputs; byte k is port k
- out_data  out  8*NUM_OUT  output registers; byte k is port k

## Operation
- Address map:
  - 0x00..NUM_OUT-1: output register k, write only.
  - 0x00..NUM_IN-1: input k, read only.
  - 0xF0: control/status.
  - 0xF4..0xF7: divisor bytes 0..3, write only.
  - All other addresses: writes ignored, reads return 0x00.
- Output write: write_strobe with port_id == k < NUM_OUT loads out_port into byte k.
- Control write (0xF0):
  - bit0 = timer enable.
  - bit7 = 1 clears the sticky missed flag.
  - Other bits are ignored.
- Status read (0xF0): {5'b0, missed, enable, pending}.
- Divisor write (0xF4+i) loads divisor bits [8i+7:8i]. Bits at or above TIMER_W are dropped. The write also clears the counter to 0.
- Timer:
  - When enabled, the counter increments each cycle.
  - When count >= divisor, the block issues a one-cycle tick and the counter returns to 0. Period = divisor+1 cycles.
  - When disabled, the counter is held at 0 and no tick is issued.
- Interrupt:
  - A tick sets pending.
  - interrupt_ack clears pending.
  - Tick and ack in the same cycle: pending stays 1 and missed is not set.
  - Tick while pending=1 with no ack: missed is set (sticky).
- The interrupt output equals pending.

## Timing
- Reset values:
  - out_data = 0, in_port = 0x00, interrupt/pending = 0, missed = 0.
  - Counter = 0, enable = 1.
  - Divisor = CLK_FREQ_HZ/TICK_HZ - 1, truncated to TIMER_W bits.
- Write latency: out_data and registers update on the clock edge that samples write_strobe. New value is visible the next cycle.
- Read latency: in_port reflects port_id sampled one clock earlier (1-cycle registered mux), every cycle.
- Tick to interrupt: pending rises on the edge after the counter reaches the divisor.
- Ack to interrupt low: 1 cycle.
- Reset mid-operation overrides every other action on that edge, including a write or ack in the same cycle.
- Divisor = 0 with enable = 1: a tick every cycle.

## Configuration
- PICO_IO_SYNC_EN defined: each in_data bit passes through a two-flop synchronizer before the read mux. Read data is 2 cycles older than the pins, plus the 1-cycle mux latency. Synchronizer flops reset to 0.
- PICO_IO_SYNC_EN undefined: in_data feeds the mux directly. The caller guarantees inputs are synchronous to clk.

## Structure
- Package pico_io_pkg holds the address constants (ADDR_CTRL = 0xF0, ADDR_DIV_BASE = 0xF4), the status/control bit positions and the byte width (8).
- Sub-module pico_io_timer (counter, divisor, enable, pending/missed flags, ack handling).
- The top level holds the output register bank, the read mux and the optional synchronizer.

## Test plan
- Reset, then write 0xA5 to 0x02 (NUM_OUT=4) -> out_data[23:16] = 0xA5 next cycle, other bytes 0. Write 0x3C to 0x05 -> out_data unchanged.
- in_data byte 3 = 0x7E, port_id = 0x03 -> in_port = 0x7E one cycle later (three with PICO_IO_SYNC_EN). port_id = 0x10 -> in_port = 0x00.
- Write divisor 9 (0xF4 = 0x09, 0xF5..0xF7 = 0) -> interrupt rises every 10 cycles. Ack 2 cycles after the rise -> interrupt low next cycle, and the next rise comes 10 cycles after the previous one.
- Withhold ack across two ticks -> status read at 0xF0 = 0x07. Write 0x81 to 0xF0 -> status 0x03.
- Assert ack on the exact tick cycle while pending -> interrupt stays 1 and missed stays 0.
- Write 0x00 to 0xF0 mid-count -> no interrupt for 100 cycles. Assert reset mid-count -> all outputs return to their reset values, enable = 1, and the divisor equals the default.
